// File: rtl/fb_port_arbiter.sv
// Single-port frame-buffer arbiter: VGA scan-out reads own the port inside the image window,
// the Sobel write stream fills the buffer outside it. Optional FB_STATS_EN adds frame/resync counters.
module fb_port_arbiter #(
    parameter int IMG_W = 960,
    parameter int IMG_H = 540,
    parameter int AW    = 20,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [10:0]   h_cnt,
    input  logic [9:0]    v_cnt,
    input  logic          hsync_in,
    input  logic          vsync_in,
    input  logic          de_in,
    input  logic          wr_valid,
    input  logic          wr_sof,
    input  logic [DW-1:0] wr_data,
    output logic          wr_ready,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [DW-1:0] pix_out,
    output logic          hsync_out,
    output logic          vsync_out,
    output logic          de_out,
    output logic          frame_done,
    output logic          resync
`ifdef FB_STATS_EN
    ,
    output logic [15:0]   frame_cnt,
    output logic [15:0]   resync_cnt
`endif
);

    localparam logic [AW-1:0] ADDR_ZERO = {AW{1'b0}};
    localparam logic [AW-1:0] ADDR_ONE  = AW'(1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(IMG_W * IMG_H - 1);
    localparam logic [DW-1:0] PIX_ZERO  = {DW{1'b0}};

    typedef enum logic [0:0] {
        S_SYNC = 1'b0,
        S_FILL = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic          mem_we_q, mem_we_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          win_p1_q, win_p2_q;
    logic [DW-1:0] pix_q, pix_d;
    logic          hs_p1_q, hs_q;
    logic          vs_p1_q, vs_q;
    logic          de_p1_q, de_q;
    logic          frame_done_q, frame_done_d;
    logic          resync_q, resync_d;

    logic          rd_win_s;
    logic          frame_start_s;
    logic [AW-1:0] rd_base_s;
    logic          xfer_s;
    logic          wr_hit_s;
    logic [AW-1:0] wr_tgt_s;

    assign rd_win_s      = ({21'd0, h_cnt} < 32'(IMG_W)) && ({22'd0, v_cnt} < 32'(IMG_H));
    assign frame_start_s = (h_cnt == 11'd0) && (v_cnt == 10'd0);
    // Origin of the raster forces the read address back to 0, healing any drift.
    assign rd_base_s     = frame_start_s ? ADDR_ZERO : rd_addr_q;
    assign wr_ready      = rst && !rd_win_s;
    assign xfer_s        = wr_valid && wr_ready;

    // Write-stream FSM next state, target address and status pulses
    always_comb begin
        state_d      = state_q;
        wr_addr_d    = wr_addr_q;
        wr_hit_s     = 1'b0;
        wr_tgt_s     = wr_addr_q;
        frame_done_d = 1'b0;
        resync_d     = 1'b0;
        case (state_q)
            S_SYNC: begin
                if (xfer_s && wr_sof) begin
                    wr_hit_s  = 1'b1;
                    wr_tgt_s  = ADDR_ZERO;
                    wr_addr_d = ADDR_ONE;
                    state_d   = S_FILL;
                end else begin
                    wr_hit_s = 1'b0;
                end
            end
            S_FILL: begin
                if (xfer_s) begin
                    wr_hit_s = 1'b1;
                    if (wr_sof) begin
                        wr_tgt_s  = ADDR_ZERO;
                        wr_addr_d = ADDR_ONE;
                        resync_d  = 1'b1;
                    end else if (wr_addr_q == LAST_ADDR) begin
                        wr_addr_d    = ADDR_ZERO;
                        frame_done_d = 1'b1;
                        state_d      = S_SYNC;
                    end else begin
                        wr_addr_d = wr_addr_q + ADDR_ONE;
                    end
                end else begin
                    wr_hit_s = 1'b0;
                end
            end
            default: begin
                state_d   = S_SYNC;
                wr_addr_d = ADDR_ZERO;
            end
        endcase
    end

    // Port mux: reads win inside the window; writes can only occur outside it
    always_comb begin
        rd_addr_d   = rd_addr_q;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;
        if (rd_win_s) begin
            rd_addr_d  = rd_base_s + ADDR_ONE;
            mem_addr_d = rd_base_s;
        end else if (wr_hit_s) begin
            rd_addr_d   = rd_base_s;
            mem_addr_d  = wr_tgt_s;
            mem_we_d    = 1'b1;
            mem_wdata_d = wr_data;
        end else begin
            rd_addr_d = rd_base_s;
        end
        if (win_p2_q) begin
            pix_d = mem_rdata;
        end else begin
            pix_d = PIX_ZERO;
        end
    end

    // All state and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_SYNC;
            rd_addr_q    <= ADDR_ZERO;
            wr_addr_q    <= ADDR_ZERO;
            mem_addr_q   <= ADDR_ZERO;
            mem_we_q     <= 1'b0;
            mem_wdata_q  <= PIX_ZERO;
            win_p1_q     <= 1'b0;
            win_p2_q     <= 1'b0;
            pix_q        <= PIX_ZERO;
            hs_p1_q      <= 1'b1;
            hs_q         <= 1'b1;
            vs_p1_q      <= 1'b1;
            vs_q         <= 1'b1;
            de_p1_q      <= 1'b0;
            de_q         <= 1'b0;
            frame_done_q <= 1'b0;
            resync_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            rd_addr_q    <= rd_addr_d;
            wr_addr_q    <= wr_addr_d;
            mem_addr_q   <= mem_addr_d;
            mem_we_q     <= mem_we_d;
            mem_wdata_q  <= mem_wdata_d;
            win_p1_q     <= rd_win_s;
            win_p2_q     <= win_p1_q;
            pix_q        <= pix_d;
            hs_p1_q      <= hsync_in;
            hs_q         <= hs_p1_q;
            vs_p1_q      <= vsync_in;
            vs_q         <= vs_p1_q;
            de_p1_q      <= de_in;
            de_q         <= de_p1_q;
            frame_done_q <= frame_done_d;
            resync_q     <= resync_d;
        end
    end

    assign mem_addr   = mem_addr_q;
    assign mem_we     = mem_we_q;
    assign mem_wdata  = mem_wdata_q;
    assign pix_out    = pix_q;
    assign hsync_out  = hs_q;
    assign vsync_out  = vs_q;
    assign de_out     = de_q;
    assign frame_done = frame_done_q;
    assign resync     = resync_q;

`ifdef FB_STATS_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [15:0] resync_cnt_q, resync_cnt_d;

    // Saturating event counters
    always_comb begin
        if (frame_done_q && (frame_cnt_q != 16'hFFFF)) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end else begin
            frame_cnt_d = frame_cnt_q;
        end
        if (resync_q && (resync_cnt_q != 16'hFFFF)) begin
            resync_cnt_d = resync_cnt_q + 16'd1;
        end else begin
            resync_cnt_d = resync_cnt_q;
        end
    end

    // Counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_cnt_q  <= 16'd0;
            resync_cnt_q <= 16'd0;
        end else begin
            frame_cnt_q  <= frame_cnt_d;
            resync_cnt_q <= resync_cnt_d;
        end
    end

    assign frame_cnt  = frame_cnt_q;
    assign resync_cnt = resync_cnt_q;
`endif

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Directed testbench for fb_port_arbiter using a small image so a whole frame fits a short run.
module tb_fb_port_arbiter;

    localparam int IMG_W = 16;
    localparam int IMG_H = 4;
    localparam int AW    = 10;
    localparam int DW    = 8;
    localparam int H_TOT = 24;
    localparam int V_TOT = 6;
    localparam int NPIX  = IMG_W * IMG_H;

    logic          clk = 1'b0;
    logic          rst;
    logic [10:0]   h_cnt;
    logic [9:0]    v_cnt;
    logic          hsync_in, vsync_in, de_in;
    logic          wr_valid, wr_sof;
    logic [DW-1:0] wr_data;
    logic          wr_ready;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [DW-1:0] pix_out;
    logic          hsync_out, vsync_out, de_out;
    logic          frame_done, resync;
`ifdef FB_STATS_EN
    logic [15:0]   frame_cnt, resync_cnt;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0] bram [0:1023];
    logic       init_req = 1'b1;

    always #5 clk = ~clk;

    fb_port_arbiter #(.IMG_W(IMG_W), .IMG_H(IMG_H), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst), .h_cnt(h_cnt), .v_cnt(v_cnt),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .de_in(de_in),
        .wr_valid(wr_valid), .wr_sof(wr_sof), .wr_data(wr_data), .wr_ready(wr_ready),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .pix_out(pix_out), .hsync_out(hsync_out), .vsync_out(vsync_out), .de_out(de_out),
        .frame_done(frame_done), .resync(resync)
`ifdef FB_STATS_EN
        , .frame_cnt(frame_cnt), .resync_cnt(resync_cnt)
`endif
    );

    // Frame-buffer model, preloaded with addr[7:0], read-first, 1-cycle latency
    always @(posedge clk) begin
        if (init_req) begin
            for (int i = 0; i < 1024; i++) bram[i] <= 8'(i);
        end else if (mem_we) begin
            bram[mem_addr] <= mem_wdata;
        end
        mem_rdata <= bram[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wstep(input logic val, input logic sof, input logic [7:0] d);
        wr_valid = val;
        wr_sof   = sof;
        wr_data  = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic       win, xfer;
        logic [7:0] e_pix, pp0, pp1, pp2;
        logic       hp0, hp1, vp0, vp1, dp0, dp1;
        int         p, last_addr, done_cnt;

        rst = 1'b0;
        h_cnt = 11'd20; v_cnt = 10'd0;
        hsync_in = 1'b0; vsync_in = 1'b0; de_in = 1'b1;
        wr_valid = 1'b1; wr_sof = 1'b1; wr_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        init_req = 1'b0;
        chk("rst_wr_ready", wr_ready, 1'b0);
        chk("rst_hsync", hsync_out, 1'b1);
        chk("rst_vsync", vsync_out, 1'b1);
        chk("rst_de", de_out, 1'b0);
        chk("rst_pix", pix_out, 8'h00);
        chk("rst_we", mem_we, 1'b0);
        chk("rst_addr", mem_addr, 10'd0);
        chk("rst_done", frame_done, 1'b0);
        chk("rst_resync", resync, 1'b0);

        h_cnt = 11'd0;
        hsync_in = 1'b1; vsync_in = 1'b1;
        rst = 1'b1;

        // Two full frames of scan-out; writer streams one frame in the gaps
        pp0 = 8'h00; pp1 = 8'h00; pp2 = 8'h00;
        hp0 = 1'b1; hp1 = 1'b1; vp0 = 1'b1; vp1 = 1'b1; dp0 = 1'b0; dp1 = 1'b0;
        p = 0; last_addr = 0; done_cnt = 0;
        for (int f = 0; f < 2; f++) begin
            for (int v = 0; v < V_TOT; v++) begin
                for (int h = 0; h < H_TOT; h++) begin
                    h_cnt = 11'(h);
                    v_cnt = 10'(v);
                    win = (h < IMG_W) && (v < IMG_H);
                    hsync_in = !((h >= 18) && (h < 20));
                    vsync_in = (v != 5);
                    de_in = win;
                    wr_valid = (p < NPIX);
                    wr_sof = (p == 0);
                    wr_data = 8'(p);
                    #1;
                    chk("wr_ready", wr_ready, !win);
                    xfer = wr_valid && wr_ready;
                    e_pix = win ? 8'(v * IMG_W + h) : 8'h00;
                    @(posedge clk);
                    #1;
                    pp2 = pp1; pp1 = pp0; pp0 = e_pix;
                    hp1 = hp0; hp0 = hsync_in;
                    vp1 = vp0; vp0 = vsync_in;
                    dp1 = dp0; dp0 = de_in;
                    chk("pix_out", pix_out, pp2);
                    chk("hsync_out", hsync_out, hp1);
                    chk("vsync_out", vsync_out, vp1);
                    chk("de_out", de_out, dp1);
                    if (win) begin
                        chk("rd_we", mem_we, 1'b0);
                        chk("rd_addr", mem_addr, 32'(v * IMG_W + h));
                        last_addr = v * IMG_W + h;
                    end else if (xfer) begin
                        chk("wr_we", mem_we, 1'b1);
                        chk("wr_addr", mem_addr, 32'(p));
                        chk("wr_data", mem_wdata, 8'(p));
                        last_addr = p;
                        p++;
                    end else begin
                        chk("idle_we", mem_we, 1'b0);
                        chk("idle_addr", mem_addr, 32'(last_addr));
                    end
                    chk("frame_done", frame_done, xfer && (p == NPIX));
                    if (frame_done) done_cnt++;
                    chk("resync_frame", resync, 1'b0);
                end
            end
        end
        chk("pixels_written", p, NPIX);
        chk("frame_done_count", done_cnt, 1);
`ifdef FB_STATS_EN
        chk("frame_cnt_one", frame_cnt, 16'd1);
`endif

        // Outside the window: pixels before sof are discarded
        h_cnt = 11'd20; v_cnt = 10'd0;
        for (int i = 0; i < 10; i++) begin
            wstep(1'b1, 1'b0, 8'(8'h10 + i));
            chk("pre_sof_we", mem_we, 1'b0);
        end
        wstep(1'b1, 1'b1, 8'hA5);
        chk("sof_we", mem_we, 1'b1);
        chk("sof_addr", mem_addr, 10'd0);
        chk("sof_data", mem_wdata, 8'hA5);
        for (int i = 1; i < 10; i++) begin
            wstep(1'b1, 1'b0, 8'(i));
            chk("fill_addr", mem_addr, 32'(i));
        end
        wstep(1'b1, 1'b1, 8'h5A);
        chk("resync_addr", mem_addr, 10'd0);
        chk("resync_we", mem_we, 1'b1);
        chk("resync_pulse", resync, 1'b1);
        wstep(1'b1, 1'b0, 8'h77);
        chk("after_resync_addr", mem_addr, 10'd1);
        chk("resync_clear", resync, 1'b0);
        wstep(1'b0, 1'b0, 8'h00);
        chk("idle_we2", mem_we, 1'b0);
        chk("idle_hold", mem_addr, 10'd1);

        // sof on the last address wins over frame completion
        for (int i = 2; i < NPIX - 1; i++) wstep(1'b1, 1'b0, 8'(i));
        chk("pre_last_addr", mem_addr, 32'(NPIX - 2));
        wstep(1'b1, 1'b1, 8'hC3);
        chk("sof_last_addr", mem_addr, 10'd0);
        chk("sof_last_resync", resync, 1'b1);
        chk("sof_last_nodone", frame_done, 1'b0);
        wstep(1'b0, 1'b0, 8'h00);
        chk("sof_last_nodone2", frame_done, 1'b0);
`ifdef FB_STATS_EN
        chk("resync_cnt_two", resync_cnt, 16'd2);
`endif

        // Reset mid-fill drops the in-flight write and returns to sync hunting
        wstep(1'b1, 1'b0, 8'h11);
        chk("pre_rst_addr", mem_addr, 10'd1);
        wr_valid = 1'b1; wr_sof = 1'b0; wr_data = 8'h22;
        #1;
        rst = 1'b0;
        #1;
        chk("mid_rst_we", mem_we, 1'b0);
        chk("mid_rst_addr", mem_addr, 10'd0);
        chk("mid_rst_ready", wr_ready, 1'b0);
        chk("mid_rst_hsync", hsync_out, 1'b1);
        chk("mid_rst_vsync", vsync_out, 1'b1);
        chk("mid_rst_pix", pix_out, 8'h00);
        @(posedge clk);
        #1;
        chk("mid_rst_we2", mem_we, 1'b0);
        rst = 1'b1;
        wstep(1'b1, 1'b0, 8'h33);
        chk("post_rst_discard", mem_we, 1'b0);
        wstep(1'b1, 1'b1, 8'h44);
        chk("post_rst_sof_we", mem_we, 1'b1);
        chk("post_rst_sof_addr", mem_addr, 10'd0);
        wstep(1'b1, 1'b0, 8'h55);
        chk("post_rst_next", mem_addr, 10'd1);
`ifdef FB_STATS_EN
        chk("post_rst_frame_cnt", frame_cnt, 16'd0);
        chk("post_rst_resync_cnt", resync_cnt, 16'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
